// File: rtl/xor_decrypter_if.sv
// Byte-stream bus for the XOR decrypter: session control, ciphertext in, plaintext out.
interface xor_decrypter_if;
    logic [7:0]  key;
    logic [2:0]  shift;
    logic [7:0]  din;
    logic        din_valid;
    logic        xor_enable;
    logic        improved_decrypt_enable;
    logic        last_data;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [15:0] byte_count;
    logic        led_complete;

    modport master (
        output key, shift, din, din_valid, xor_enable, improved_decrypt_enable, last_data,
        input  dout, dout_valid, byte_count, led_complete
    );

    modport slave (
        input  key, shift, din, din_valid, xor_enable, improved_decrypt_enable, last_data,
        output dout, dout_valid, byte_count, led_complete
    );
endinterface

// File: rtl/xor_decrypter.sv
// Session-based XOR byte decrypter with a simple (fixed key) and a chained (previous ciphertext) mode.
//   state | meaning
//   IDLE  | waiting for an enable to open a session
//   RUN   | accepting ciphertext bytes
//   DONE  | session ended on last_data; waiting for both enables low
module xor_decrypter (
    input  logic             clk,
    input  logic             start_reset_n,
    xor_decrypter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [7:0]  chain_reg;
    logic        chained_mode;
    logic        any_enable;
    logic        accept;
    logic        session_start;
    logic [7:0]  key_stream;
    logic [15:0] rot_tmp;

    assign any_enable    = bus.xor_enable | bus.improved_decrypt_enable;
    assign accept        = (state == RUN) && bus.din_valid;
    assign session_start = (state == IDLE) && any_enable;

    // Circular left rotate: the upper byte of the doubled word shifted left.
    assign rot_tmp    = {chain_reg, chain_reg} << bus.shift;
    assign key_stream = rot_tmp[15:8];

    always_ff @(posedge clk or negedge start_reset_n) begin
        if (!start_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_enable) state_next = RUN;
            end
            RUN: begin
                // An accepted byte always completes, even if the enables drop with it.
                if (accept && bus.last_data) state_next = DONE;
                else if (!any_enable)        state_next = IDLE;
            end
            DONE: begin
                if (!any_enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge start_reset_n) begin
        if (!start_reset_n) begin
            chain_reg        <= 8'h00;
            chained_mode     <= 1'b0;
            bus.dout         <= 8'h00;
            bus.dout_valid   <= 1'b0;
            bus.byte_count   <= 16'h0000;
            bus.led_complete <= 1'b0;
        end else begin
            bus.dout_valid <= accept;
            if (session_start) begin
                chain_reg        <= bus.key;
                chained_mode     <= bus.improved_decrypt_enable;
                bus.byte_count   <= 16'h0000;
                bus.led_complete <= 1'b0;
            end
            if (accept) begin
                bus.dout <= bus.din ^ key_stream;
                if (chained_mode) chain_reg <= bus.din;
                if (bus.byte_count != 16'hFFFF) bus.byte_count <= bus.byte_count + 16'd1;
                if (bus.last_data) bus.led_complete <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xor_decrypter.sv
// Directed testbench for xor_decrypter with hand-computed expected plaintext.
module tb_xor_decrypter;
    logic clk = 1'b0;
    logic start_reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    xor_decrypter_if bus ();

    xor_decrypter dut (
        .clk           (clk),
        .start_reset_n (start_reset_n),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic l);
        @(negedge clk);
        bus.din_valid = v;
        bus.din       = d;
        bus.shift     = s;
        bus.last_data = l;
    endtask

    task automatic set_en(input logic xe, input logic ie, input logic [7:0] k);
        @(negedge clk);
        bus.xor_enable              = xe;
        bus.improved_decrypt_enable = ie;
        bus.key                     = k;
        bus.din_valid               = 1'b0;
        bus.last_data               = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", bus.dout); end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.dout_valid); end
        total++; if (bus.byte_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h want=0000", bus.byte_count); end
        total++; if (bus.led_complete !== 1'b0) begin bad++; $display("FAIL reset_led got=%b want=0", bus.led_complete); end
        @(negedge clk);
        start_reset_n = 1'b1;
        // Data before any enable must be ignored.
        drive(1'b1, 8'hFF, 3'd0, 1'b0);
        step();
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus.dout_valid); end
    endtask

    task automatic test_simple();
        set_en(1'b1, 1'b0, 8'hA8);
        step();
        bus.key = 8'h00; // mid-session key change must be ignored
        drive(1'b1, 8'hFF, 3'd0, 1'b0);
        step();
        total++; if (bus.dout !== 8'h57 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL simple_s0 got=%h/%b want=57/1", bus.dout, bus.dout_valid); end
        drive(1'b1, 8'hFF, 3'd1, 1'b0);
        step();
        total++; if (bus.dout !== 8'hAE || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL simple_s1 got=%h/%b want=AE/1", bus.dout, bus.dout_valid); end
        drive(1'b1, 8'hFF, 3'd7, 1'b0);
        step();
        total++; if (bus.dout !== 8'hAB || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL simple_s7 got=%h/%b want=AB/1", bus.dout, bus.dout_valid); end
        total++; if (bus.byte_count !== 16'd3) begin bad++; $display("FAIL simple_count got=%0d want=3", bus.byte_count); end
        // last_data without din_valid is ignored; dout holds.
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        step();
        total++; if (bus.dout_valid !== 1'b0 || bus.dout !== 8'hAB) begin bad++; $display("FAIL simple_hold got=%h/%b want=AB/0", bus.dout, bus.dout_valid); end
        total++; if (bus.led_complete !== 1'b0) begin bad++; $display("FAIL last_no_valid got=%b want=0", bus.led_complete); end
        drive(1'b1, 8'h00, 3'd0, 1'b0);
        step();
        total++; if (bus.dout !== 8'hA8) begin bad++; $display("FAIL simple_key_hold got=%h want=A8", bus.dout); end
        // Abort: enables low with no accepted byte.
        set_en(1'b0, 1'b0, 8'h00);
        step();
        drive(1'b1, 8'h55, 3'd0, 1'b0);
        step();
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", bus.dout_valid); end
        total++; if (bus.led_complete !== 1'b0 || bus.byte_count !== 16'd4) begin bad++; $display("FAIL abort_state got=%b/%0d want=0/4", bus.led_complete, bus.byte_count); end
    endtask

    task automatic test_back_to_back_chained();
        set_en(1'b1, 1'b1, 8'hA8); // both enables: chained wins
        step();
        total++; if (bus.byte_count !== 16'd0) begin bad++; $display("FAIL chain_clear got=%0d want=0", bus.byte_count); end
        drive(1'b1, 8'h12, 3'd0, 1'b0);
        step();
        total++; if (bus.dout !== 8'hBA || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL chain_b0 got=%h/%b want=BA/1", bus.dout, bus.dout_valid); end
        drive(1'b1, 8'h34, 3'd0, 1'b1);
        step();
        total++; if (bus.dout !== 8'h26 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL chain_b1 got=%h/%b want=26/1", bus.dout, bus.dout_valid); end
        total++; if (bus.led_complete !== 1'b1 || bus.byte_count !== 16'd2) begin bad++; $display("FAIL chain_done got=%b/%0d want=1/2", bus.led_complete, bus.byte_count); end
        // In DONE with enables still high, data is ignored.
        drive(1'b1, 8'h77, 3'd0, 1'b0);
        step();
        total++; if (bus.dout_valid !== 1'b0 || bus.byte_count !== 16'd2 || bus.dout !== 8'h26) begin bad++; $display("FAIL done_ignore got=%h/%b/%0d want=26/0/2", bus.dout, bus.dout_valid, bus.byte_count); end
        set_en(1'b0, 1'b0, 8'h00);
        step();
        total++; if (bus.led_complete !== 1'b1) begin bad++; $display("FAIL led_sticky got=%b want=1", bus.led_complete); end
    endtask

    task automatic test_after_done();
        set_en(1'b1, 1'b0, 8'h01);
        step();
        total++; if (bus.led_complete !== 1'b0 || bus.byte_count !== 16'd0) begin bad++; $display("FAIL new_session got=%b/%0d want=0/0", bus.led_complete, bus.byte_count); end
        // Enables dropped together with an accepted byte: byte still processed.
        @(negedge clk);
        bus.xor_enable = 1'b0;
        bus.din_valid  = 1'b1;
        bus.din        = 8'h08;
        bus.shift      = 3'd3;
        step();
        total++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b1 || bus.byte_count !== 16'd1) begin bad++; $display("FAIL after_done got=%h/%b/%0d want=00/1/1", bus.dout, bus.dout_valid, bus.byte_count); end
        drive(1'b1, 8'h08, 3'd3, 1'b0);
        step();
        total++; if (bus.dout_valid !== 1'b0 || bus.byte_count !== 16'd1) begin bad++; $display("FAIL drop_idle got=%b/%0d want=0/1", bus.dout_valid, bus.byte_count); end
    endtask

    task automatic test_reset_midstream();
        set_en(1'b1, 1'b0, 8'h3C);
        step();
        drive(1'b1, 8'h3C, 3'd0, 1'b0);
        step();
        total++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL pre_reset got=%h/%b want=00/1", bus.dout, bus.dout_valid); end
        bus.din = 8'hC3;
        step();
        #1;
        start_reset_n = 1'b0;
        #1;
        total++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0 || bus.byte_count !== 16'd0 || bus.led_complete !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b/%0d/%b want=00/0/0/0", bus.dout, bus.dout_valid, bus.byte_count, bus.led_complete); end
        @(negedge clk);
        bus.xor_enable = 1'b0;
        start_reset_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.dout_valid !== 1'b0 || bus.byte_count !== 16'd0) begin bad++; $display("FAIL post_reset%0d got=%b/%0d want=0/0", i, bus.dout_valid, bus.byte_count); end
        end
    endtask

    initial begin
        bus.key = 8'h00; bus.shift = 3'd0; bus.din = 8'h00; bus.din_valid = 1'b0;
        bus.xor_enable = 1'b0; bus.improved_decrypt_enable = 1'b0; bus.last_data = 1'b0;
        test_reset();
        test_simple();
        test_back_to_back_chained();
        test_after_done();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/xor_decrypter.md
XOR_DECRYPTER -- requirements
Module: xor_decrypter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port start_reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port key, input, 8, the session key, sampled only at session start.
REQ-004 SHALL have port shift, input, 3, the left-rotate amount applied to the key, sampled on every accepted byte.
REQ-005 SHALL have port din, input, 8, the ciphertext byte.
REQ-006 SHALL have port din_valid, input, 1; when high in RUN, din is accepted that cycle.
REQ-007 SHALL have port xor_enable, input, 1, a level request for a simple-mode session.
REQ-008 SHALL have port improved_decrypt_enable, input, 1, a level request for a chained-mode session.
REQ-009 SHALL have port last_data, input, 1; when high with an accepted byte, that byte is final.
REQ-010 SHALL have port dout, output, 8, the registered plaintext byte.
REQ-011 SHALL have port dout_valid, output, 1, a one-cycle strobe qualifying dout.
REQ-012 SHALL have port byte_count, output, 16, the number of bytes decrypted in the current or last session.
REQ-013 SHALL have port led_complete, output, 1, high once a session has ended on last_data.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, if either enable is high, the FSM SHALL go to RUN next cycle and, at that transition:
- latch key into chain_reg;
- latch mode (chained if improved_decrypt_enable is high, else simple);
- clear byte_count and led_complete.
REQ-016 If both enables are high in IDLE, chained mode SHALL win.
REQ-017 SHALL ignore din_valid in IDLE and DONE: no dout_valid, no count change.
REQ-018 For an accepted byte in RUN, the next cycle SHALL present:
- dout = din XOR rotl(chain_reg, shift);
- dout_valid = 1.
Latency is exactly 1 cycle.
REQ-019 rotl SHALL be an 8-bit circular left rotate; shift=0 passes the key unchanged.
REQ-020 Simple mode SHALL hold chain_reg constant for the whole session.
REQ-021 Chained mode SHALL load chain_reg <= din on every accepted byte, so the next byte uses the previous ciphertext byte.
REQ-022 Each accepted byte SHALL increment byte_count, saturating at 16'hFFFF with no wrap.
REQ-023 SHALL accept back-to-back bytes every cycle with no stall.
REQ-024 An accepted byte with last_data=1 SHALL be decrypted normally, and next cycle the FSM SHALL be in DONE with led_complete=1.
REQ-025 SHALL ignore last_data when din_valid=0.
REQ-026 If both enables are low in RUN with no accepted byte that cycle, the FSM SHALL abort to IDLE next cycle:
- led_complete stays 0;
- byte_count is held.
REQ-027 If both enables are low in the same cycle as an accepted byte, the FSM SHALL still process that byte (and honour last_data), then go to IDLE or DONE.
REQ-028 SHALL ignore changes to the enables or key mid-session, except as in REQ-026/027.
REQ-029 DONE SHALL go to IDLE when both enables are low.
REQ-030 led_complete SHALL stay 1 until the next session starts or reset.
REQ-031 dout SHALL hold its last value when dout_valid=0.

Reset
REQ-032 While start_reset_n=0, asynchronously, SHALL set:
- FSM = IDLE;
- dout = 0, dout_valid = 0;
- byte_count = 0, led_complete = 0;
- chain_reg = 0, mode = simple.
REQ-033 Reset mid-session SHALL discard any in-flight byte; dout_valid SHALL be 0 in the first cycle after release.
REQ-034 After release, SHALL require an enable high in IDLE before accepting data.

Verification
REQ-035 Simple mode: key=0xA8, shift=0, din=0xFF with din_valid -> dout=0x57, dout_valid=1 one cycle later.
REQ-036 Same session, shift=1, din=0xFF -> dout=0xAE; shift=7, din=0xFF -> dout=0xAB; byte_count=3.
REQ-037 Chained mode: key=0xA8, shift=0, bytes 0x12, 0x34 back-to-back, last_data on 0x34:
- dout sequence 0xBA, 0x26 on consecutive cycles;
- then led_complete=1, FSM=DONE, byte_count=2.
REQ-038 Both enables dropped mid-session with no byte accepted -> FSM returns to IDLE, led_complete=0; din_valid there yields no dout_valid.
REQ-039 start_reset_n pulsed low during a back-to-back stream -> all outputs 0 immediately; dout_valid stays 0 after release until a new session starts.
REQ-040 A session after DONE with key=0x01, shift=3, din=0x08 -> led_complete cleared on session start, dout=0x00, byte_count=1.
